iram_loader: RTL

Boot-time writer for the instruction RAM. It takes a byte stream (e.g. from a UART receiver), frames it as a length-prefixed, checksummed program image, packs bytes into 32-bit little-endian words and issues single-cycle word writes on the same `mem_wr`/`addr`/`wdata` bus the IRAM wrapper exposes. It holds the core in reset until an image has loaded and verified.

---
 rtl/iram_loader_pkg.sv | 21 ++
 rtl/iram_loader_if.sv | 22 ++
 rtl/iram_ld_packer.sv | 39 +++
 rtl/iram_loader.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/iram_loader_pkg.sv
// iram_loader_pkg: shared types and constants for the IRAM boot loader.
//   state_t   - loader session state
//   lane_t    - byte-lane index inside a 32-bit word
//   HDR_BYTES - bytes in the length header (also bytes per payload word)
package iram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WR,
    CHK,
    DONE,
    ERR
  } state_t;

  typedef logic [1:0] lane_t;

  localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/iram_loader_if.sv
// iram_loader_if: byte-stream input and IRAM write bus of the loader.
//   rx_valid/rx_data/rx_ready - byte stream, transfer on rx_valid & rx_ready
//   mem_wr/addr/wdata         - single-cycle IRAM word write
// master: the loader side. slave: byte source / IRAM side.
interface iram_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_wr;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_wr, addr, wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_wr, addr, wdata
  );
endinterface

// File: rtl/iram_ld_packer.sv
// iram_ld_packer: shifts accepted bytes into a 32-bit little-endian word.
//   clk, rstn - clock, synchronous active-low reset
//   clr       - restart assembly at lane 0
//   en        - a byte is accepted this cycle
//   din       - accepted byte
//   word      - word including the current byte (valid when full)
//   full      - current byte completes the word
module iram_ld_packer
  import iram_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        full
);

  logic [23:0] shreg;
  lane_t       lane;

  // Newest byte enters at the top, so after four bytes the first one sits
  // in bits [7:0]. The completed word is presented combinationally so the
  // FSM can act on it in the same cycle as the last byte.
  assign word = {din, shreg};
  assign full = en && (lane == lane_t'(HDR_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      shreg <= '0;
      lane  <= '0;
    end else if (en) begin
      shreg <= word[31:8];
      lane  <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/iram_loader.sv
// iram_loader: boot-time IRAM writer. Receives a length-prefixed, XOR-checked
// program image as a byte stream, writes it word by word and releases the
// core reset once the image has verified.
//   sclk, rstn   - clock, synchronous active-low reset
//   start        - begin a load session (ignored while busy)
//   bus          - byte stream in, IRAM word writes out
//   busy         - session in progress
//   done         - image loaded and checksum verified
//   err          - session failed (bad length, checksum or timeout)
//   core_rstn    - core reset, high only while done
//   words_loaded - words written in the current session
module iram_loader
  import iram_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 8192,
  parameter int          CNT_W       = 14,
  parameter int          TIMEOUT     = 1_000_000
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              start,
  iram_loader_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_rstn,
  output logic [CNT_W-1:0]  words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [CNT_W-1:0]  idx;
  logic [31:0]       n_words;
  logic [7:0]        xor_acc;
  logic [TW-1:0]     tmo_cnt;

  logic        accept;
  logic        launch;
  logic        pk_en;
  logic        pk_full;
  logic [31:0] pk_word;
  logic        tmo_hit;
  logic        hdr_bad;
  logic        chk_bad;
  logic        fail;

  always_comb begin
    accept  = bus.rx_valid & bus.rx_ready;
    launch  = start & ((state == IDLE) | (state == DONE) | (state == ERR));
    pk_en   = accept & ((state == HDR) | (state == DATA));
    // rx_ready is high exactly in HDR, DATA and CHK, the states that time out.
    tmo_hit = bus.rx_ready & ~accept & (tmo_cnt == TW'(TIMEOUT - 1));
    // Full 32-bit compare so an oversize header can never alias into range.
    hdr_bad = (state == HDR) & pk_full &
              ((pk_word == '0) | (pk_word > 32'(DEPTH_WORDS)));
    chk_bad = (state == CHK) & accept & (bus.rx_data != xor_acc);
    fail    = tmo_hit | hdr_bad | chk_bad;
  end

  iram_ld_packer u_packer (
    .clk  (sclk),
    .rstn (rstn),
    .clr  (launch),
    .en   (pk_en),
    .din  (bus.rx_data),
    .word (pk_word),
    .full (pk_full)
  );

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state        <= IDLE;
      bus.rx_ready <= 1'b0;
      bus.mem_wr   <= 1'b0;
      bus.addr     <= BASE_ADDR;
      bus.wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      core_rstn    <= 1'b0;
      words_loaded <= '0;
      idx          <= '0;
      n_words      <= '0;
      xor_acc      <= '0;
      tmo_cnt      <= '0;
    end else begin
      bus.mem_wr <= 1'b0;

      if (bus.rx_ready) begin
        tmo_cnt <= accept ? '0 : tmo_cnt + TW'(1);
      end

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR;
            bus.rx_ready <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            core_rstn    <= 1'b0;
            words_loaded <= '0;
            idx          <= '0;
            xor_acc      <= '0;
            tmo_cnt      <= '0;
          end
        end

        HDR: begin
          if (pk_full) begin
            n_words <= pk_word;
            state   <= DATA;
          end
        end

        DATA: begin
          if (accept) begin
            xor_acc <= xor_acc ^ bus.rx_data;
          end
          if (pk_full) begin
            state        <= WR;
            bus.rx_ready <= 1'b0;
            bus.mem_wr   <= 1'b1;
            bus.addr     <= BASE_ADDR + (32'(idx) << 2);
            bus.wdata    <= pk_word;
          end
        end

        WR: begin
          idx          <= idx + CNT_W'(1);
          words_loaded <= words_loaded + CNT_W'(1);
          bus.rx_ready <= 1'b1;
          state        <= (32'(idx) + 32'd1 == n_words) ? CHK : DATA;
        end

        CHK: begin
          if (accept) begin
            state        <= DONE;
            bus.rx_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            core_rstn    <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // Any failure overrides the normal next-state chosen above.
      if (fail) begin
        state        <= ERR;
        bus.rx_ready <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b0;
        err          <= 1'b1;
        core_rstn    <= 1'b0;
      end
    end
  end

endmodule
